bp_io_cmd_mux: RTL and testbench
================================

BP_IO_CMD_MUX -- requirements
Module: bp_io_cmd_mux

Interface
- REQ-001 SHALL have parameter num_ch_p, default 2: number of IO command sources (legal 2..8).
- REQ-002 SHALL have parameter cmd_width_p, default 128: IO command payload width.
- REQ-003 SHALL have parameter resp_width_p, default 128: IO response payload width.
- REQ-004 SHALL have parameter addr_width_p, default 40: width of the per-channel address sideband.
- REQ-005 SHALL have parameter did_width_p, default 3: destination-ID width, taken from addr[addr_width_p-1 -: did_width_p].
- REQ-006 SHALL have parameter dev_lsb_p, default 20, and host_dev_p, default 1: 4-bit device field addr[dev_lsb_p +: 4] and host device code.
- REQ-007 SHALL have parameter max_credits_p, default 4: maximum outstanding commands (power of 2, 2..16).
- REQ-008 SHALL have port clk_i, input, 1: single clock.
- REQ-009 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
- REQ-010 SHALL have port cmd_i, input, num_ch_p*cmd_width_p: per-channel commands.
- REQ-011 SHALL have port cmd_addr_i, input, num_ch_p*addr_width_p: per-channel command address.
- REQ-012 SHALL have ports cmd_v_i (input) and cmd_yumi_o (output), each num_ch_p: valid->yumi handshake per channel.
- REQ-013 SHALL have ports io_cmd_o (output, cmd_width_p), dst_did_o (output, did_width_p), io_cmd_v_o (output, 1) and io_cmd_ready_i (input, 1): outbound ready/valid.
- REQ-014 SHALL have ports io_resp_i (input, resp_width_p), io_resp_v_i (input, 1) and io_resp_yumi_o (output, 1): inbound response.
- REQ-015 SHALL have ports resp_o (output, resp_width_p), resp_v_o (output, num_ch_p) and resp_ready_i (input, num_ch_p): per-channel response return.
- REQ-016 SHALL have ports credits_o (output, $clog2(max_credits_p+1)) giving the outstanding count, and err_o (output, 1) giving the sticky error flag.

Function
- REQ-017 SHALL deem channel c eligible when cmd_v_i[c]=1, the tag FIFO is not full, and the output register is empty or draining this cycle (io_cmd_v_o&io_cmd_ready_i).
- REQ-018 SHALL grant at most one eligible channel per cycle, round-robin starting at (last granted+1) mod num_ch_p; the pointer SHALL advance only on grant.
- REQ-019 SHALL assert cmd_yumi_o[c] combinationally in the grant cycle only; all other bits SHALL be 0.
- REQ-020 SHALL on grant load cmd_i[c] into io_cmd_o and the decoded destination into dst_did_o, with io_cmd_v_o=1 from the next cycle (1-cycle latency, full throughput).
- REQ-021 SHALL hold io_cmd_o and dst_did_o stable while io_cmd_v_o=1 and io_cmd_ready_i=0.
- REQ-022 SHALL decode dst_did_o as all-ones when the DID field is 0 and the device field equals host_dev_p; otherwise dst_did_o SHALL equal the DID field.
- REQ-023 SHALL push channel index c into an in-order tag FIFO of depth max_credits_p on grant; credits_o SHALL equal FIFO occupancy.
- REQ-024 SHALL drive resp_o=io_resp_i; when the FIFO is non-empty with head h, resp_v_o[h]=io_resp_v_i and all other bits 0.
- REQ-025 SHALL assert io_resp_yumi_o=io_resp_v_i & resp_ready_i[h] with the FIFO non-empty, and SHALL pop the FIFO on yumi.
- REQ-026 SHALL, when push and pop coincide, leave occupancy unchanged; a full FIFO SHALL block grants even with a same-cycle pop.
- REQ-027 SHALL, on io_resp_v_i=1 with the FIFO empty, drive resp_v_o=0 and io_resp_yumi_o=0, and set err_o until reset.
- REQ-028 SHALL wrap FIFO pointers modulo max_credits_p.

Reset
- REQ-029 SHALL, while reset_n_i=0 (asynchronously), clear io_cmd_v_o, cmd_yumi_o, resp_v_o, io_resp_yumi_o, err_o and credits_o to 0, empty the FIFO, and point the round-robin pointer at channel 0; io_cmd_o and dst_did_o are don't-care.
- REQ-030 SHALL on reset mid-operation discard the outstanding tags and any held command; no handshake SHALL occur in the first cycle after deassertion.

Verification
- REQ-031 SHALL be checked with both channels valid continuously and io_cmd_ready_i=1 -> grants alternate 0,1,0,1 and credits_o increments each cycle until it reaches 4, after which grants stop.
- REQ-032 SHALL be checked with addr DID=0, dev=1 -> dst_did_o=3'b111; addr DID=5 -> dst_did_o=5.
- REQ-033 SHALL be checked by issuing ch1, ch0, ch1 commands then sending 3 responses -> resp_v_o = 2'b10, 2'b01, 2'b10 in order and credits_o returns to 0.
- REQ-034 SHALL be checked with io_cmd_ready_i=0 for 5 cycles while a command is held -> io_cmd_o stable and no cmd_yumi_o asserted.
- REQ-035 SHALL be checked by applying a response with credits_o=0 -> io_resp_yumi_o=0 and err_o=1 held until reset.
- REQ-036 SHALL be checked by asserting reset_n_i low with 3 commands outstanding -> credits_o=0 and io_cmd_v_o=0 immediately, and the next grant goes to channel 0.

Source files
------------

// File: rtl/bp_io_cmd_mux.sv
// Round-robin IO command mux with an in-order tag FIFO that routes
// responses back to the channel that issued each outstanding command.
module bp_io_cmd_mux #(
  parameter int num_ch_p      = 2,
  parameter int cmd_width_p   = 128,
  parameter int resp_width_p  = 128,
  parameter int addr_width_p  = 40,
  parameter int did_width_p   = 3,
  parameter int dev_lsb_p     = 20,
  parameter int host_dev_p    = 1,
  parameter int max_credits_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_ch_p*cmd_width_p-1:0]   cmd_i,
  input  logic [num_ch_p*addr_width_p-1:0]  cmd_addr_i,
  input  logic [num_ch_p-1:0]               cmd_v_i,
  output logic [num_ch_p-1:0]               cmd_yumi_o,
  output logic [cmd_width_p-1:0]            io_cmd_o,
  output logic [did_width_p-1:0]            dst_did_o,
  output logic                              io_cmd_v_o,
  input  logic                              io_cmd_ready_i,
  input  logic [resp_width_p-1:0]           io_resp_i,
  input  logic                              io_resp_v_i,
  output logic                              io_resp_yumi_o,
  output logic [resp_width_p-1:0]           resp_o,
  output logic [num_ch_p-1:0]               resp_v_o,
  input  logic [num_ch_p-1:0]               resp_ready_i,
  output logic [$clog2(max_credits_p+1)-1:0] credits_o,
  output logic                              err_o
);

  localparam int tw = $clog2(num_ch_p);
  localparam int pw = $clog2(max_credits_p);
  localparam int cw = $clog2(max_credits_p+1);

  logic [tw-1:0] ptr, ptr_nxt, gsel, head;
  logic [tw-1:0] tags [max_credits_p];
  logic [pw-1:0] rptr, wptr;
  logic          gv, live, full, empty, avail;
  logic          push, pop;
  logic [addr_width_p-1:0] addr_sel;
  logic [did_width_p-1:0]  did, dst;
  logic [3:0]              dev;
  logic                    unused_addr;
  int                      j;

  assign full  = credits_o == cw'(max_credits_p);
  assign empty = credits_o == '0;
  assign avail = ~io_cmd_v_o | io_cmd_ready_i;

  // live keeps the first cycle after reset release handshake-free
  always_comb begin
    gv   = 1'b0;
    gsel = '0;
    j    = 0;
    if (live && avail && !full) begin
      for (int i = 0; i < num_ch_p; i++) begin
        j = (int'(ptr) + i) % num_ch_p;
        if (!gv && cmd_v_i[j]) begin
          gv   = 1'b1;
          gsel = tw'(j);
        end
      end
    end
  end

  assign ptr_nxt = (gsel == tw'(num_ch_p-1)) ? '0 : gsel + 1'b1;
  assign push = gv;
  assign cmd_yumi_o = gv ? (num_ch_p'(1) << gsel) : '0;

  assign addr_sel = cmd_addr_i[gsel*addr_width_p +: addr_width_p];
  assign did = addr_sel[addr_width_p-1 -: did_width_p];
  assign dev = addr_sel[dev_lsb_p +: 4];
  assign dst = (did == '0 && dev == 4'(host_dev_p)) ? '1 : did;
  assign unused_addr = ^cmd_addr_i;

  assign head = tags[rptr];
  assign resp_o = io_resp_i;
  assign resp_v_o = (!empty && io_resp_v_i)
                  ? (num_ch_p'(1) << head) : '0;
  assign io_resp_yumi_o = !empty & io_resp_v_i & resp_ready_i[head];
  assign pop = io_resp_yumi_o;

  always_ff @(posedge clk_i) begin
    if (push) tags[wptr] <= gsel;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      live       <= 1'b0;
      ptr        <= '0;
      io_cmd_v_o <= 1'b0;
      io_cmd_o   <= '0;
      dst_did_o  <= '0;
      rptr       <= '0;
      wptr       <= '0;
      credits_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (push) begin
        io_cmd_v_o <= 1'b1;
        io_cmd_o   <= cmd_i[gsel*cmd_width_p +: cmd_width_p];
        dst_did_o  <= dst;
        ptr        <= ptr_nxt;
        wptr       <= wptr + 1'b1;
      end else if (io_cmd_ready_i) begin
        io_cmd_v_o <= 1'b0;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)
        credits_o <= credits_o + 1'b1;
      else if (pop && !push)
        credits_o <= credits_o - 1'b1;
      if (io_resp_v_i && empty) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_io_cmd_mux.sv
// Directed and random checks of bp_io_cmd_mux against a queue-based
// reference model of grants, held command and in-order responses.
module tb_bp_io_cmd_mux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] cmd = '0;
  logic [79:0]  addr = '0;
  logic [1:0]   cv = '0;
  logic [1:0]   cmd_yumi_o;
  logic [127:0] io_cmd_o;
  logic [2:0]   dst_did_o;
  logic         io_cmd_v_o;
  logic         rdy = 1'b0;
  logic [127:0] rsp = '0;
  logic         rv = 1'b0;
  logic         io_resp_yumi_o;
  logic [127:0] resp_o;
  logic [1:0]   resp_v_o;
  logic [1:0]   rr = '0;
  logic [2:0]   credits_o;
  logic         err_o;

  int total = 0;
  int bad = 0;

  int q[$];
  int glog[$];
  logic         ovalid;
  logic [127:0] ocmd;
  logic [2:0]   odid;
  logic         merr;
  logic         alive;
  int           ptr;

  bp_io_cmd_mux dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .cmd_i(cmd), .cmd_addr_i(addr),
    .cmd_v_i(cv), .cmd_yumi_o(cmd_yumi_o),
    .io_cmd_o(io_cmd_o), .dst_did_o(dst_did_o),
    .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(rdy),
    .io_resp_i(rsp), .io_resp_v_i(rv),
    .io_resp_yumi_o(io_resp_yumi_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o),
    .resp_ready_i(rr), .credits_o(credits_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic fail(string t, logic [127:0] o, logic [127:0] e);
    bad++;
    $error("FAIL %s obs=%0h exp=%0h", t, o, e);
  endtask

  task automatic model_reset();
    q.delete();
    ovalid = 1'b0;
    ocmd = '0;
    odid = '0;
    merr = 1'b0;
    alive = 1'b0;
    ptr = 0;
  endtask

  task automatic set_ch(int c, logic [2:0] did, logic [3:0] dev);
    logic [39:0] a;
    a[31:0] = $urandom;
    a[39:32] = 8'($urandom);
    a[39:37] = did;
    a[23:20] = dev;
    addr[c*40 +: 40] = a;
    cmd[c*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [2:0] exp_dst(int c);
    logic [2:0] d;
    logic [3:0] v;
    d = addr[c*40+37 +: 3];
    v = addr[c*40+20 +: 4];
    return (d == 3'd0 && v == 4'd1) ? 3'b111 : d;
  endfunction

  task automatic step();
    int g, h;
    bit was_empty;
    logic [1:0] ey, erv;
    logic ery;
    #1;
    g = -1;
    if (alive && q.size() < 4 && (!ovalid || rdy))
      for (int i = 0; i < 2; i++)
        if (g < 0 && cv[(ptr + i) % 2]) g = (ptr + i) % 2;
    ey = (g >= 0) ? 2'(1 << g) : 2'b00;
    erv = 2'b00;
    ery = 1'b0;
    was_empty = (q.size() == 0);
    if (!was_empty) begin
      h = q[0];
      if (rv) erv[h] = 1'b1;
      ery = rv && rr[h];
    end
    total++;
    if (credits_o !== 3'(q.size()))
      fail("credits", credits_o, q.size());
    total++;
    if (io_cmd_v_o !== ovalid)
      fail("cmd_v", io_cmd_v_o, ovalid);
    if (ovalid) begin
      total++;
      if (io_cmd_o !== ocmd)
        fail("cmd", io_cmd_o, ocmd);
      total++;
      if (dst_did_o !== odid)
        fail("dst", dst_did_o, odid);
    end
    total++;
    if (err_o !== merr)
      fail("err", err_o, merr);
    total++;
    if (cmd_yumi_o !== ey)
      fail("cmd_yumi", cmd_yumi_o, ey);
    total++;
    if (resp_v_o !== erv)
      fail("resp_v", resp_v_o, erv);
    total++;
    if (io_resp_yumi_o !== ery)
      fail("resp_yumi", io_resp_yumi_o, ery);
    total++;
    if (resp_o !== rsp)
      fail("resp", resp_o, rsp);
    if (ery) void'(q.pop_front());
    if (rv && was_empty) merr = 1'b1;
    if (g >= 0) begin
      q.push_back(g);
      glog.push_back(g);
      ovalid = 1'b1;
      ocmd = cmd[g*128 +: 128];
      odid = exp_dst(g);
      ptr = (g + 1) % 2;
    end else if (rdy) begin
      ovalid = 1'b0;
    end
    alive = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    cv = 2'b00;
    rv = 1'b1;
    rr = 2'b11;
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    rv = 1'b0;
    total++;
    if (credits_o !== 3'd0)
      fail("drained", credits_o, 0);
  endtask

  initial begin
    logic [127:0] held;
    logic [1:0] rexp [3];
    model_reset();
    set_ch(0, 3'd2, 4'd0);
    set_ch(1, 3'd3, 4'd0);
    repeat (2) @(negedge clk);
    total++;
    if (credits_o !== 3'd0)
      fail("rst_credits", credits_o, 0);
    total++;
    if (io_cmd_v_o !== 1'b0)
      fail("rst_cmd_v", io_cmd_v_o, 0);
    total++;
    if (err_o !== 1'b0)
      fail("rst_err", err_o, 0);
    rst_n = 1'b1;

    cv = 2'b11;
    rdy = 1'b1;
    glog.delete();
    repeat (7) step();
    total++;
    if (glog.size() !== 4)
      fail("rr_count", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) begin
      total++;
      if (glog[k] !== k % 2)
        fail("rr_order", glog[k], k % 2);
    end
    total++;
    if (credits_o !== 3'd4)
      fail("full_credits", credits_o, 4);
    drain();

    set_ch(0, 3'd0, 4'd1);
    cv = 2'b01;
    step();
    cv = 2'b00;
    total++;
    if (dst_did_o !== 3'b111)
      fail("did_host", dst_did_o, 7);
    set_ch(1, 3'd5, 4'd1);
    cv = 2'b10;
    step();
    cv = 2'b00;
    total++;
    if (dst_did_o !== 3'd5)
      fail("did_5", dst_did_o, 5);
    drain();

    cv = 2'b10; step();
    cv = 2'b01; step();
    cv = 2'b10; step();
    cv = 2'b00;
    rexp[0] = 2'b10; rexp[1] = 2'b01; rexp[2] = 2'b10;
    rv = 1'b1;
    rr = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (resp_v_o !== rexp[k])
        fail("resp_order", resp_v_o, rexp[k]);
      step();
    end
    rv = 1'b0;
    total++;
    if (credits_o !== 3'd0)
      fail("order_credits", credits_o, 0);

    rdy = 1'b0;
    cv = 2'b11;
    step();
    held = io_cmd_o;
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 3'($urandom), 4'($urandom));
      set_ch(1, 3'($urandom), 4'($urandom));
      step();
      total++;
      if (io_cmd_o !== held)
        fail("hold_cmd", io_cmd_o, held);
    end
    rdy = 1'b1;
    cv = 2'b00;
    step();
    drain();

    rv = 1'b1;
    rr = 2'b11;
    step();
    step();
    total++;
    if (err_o !== 1'b1)
      fail("err_set", err_o, 1);
    rv = 1'b0;
    repeat (3) step();
    total++;
    if (err_o !== 1'b1)
      fail("err_sticky", err_o, 1);

    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 1) == 1)
          set_ch(c, 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 2)));
      cv = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) == 0);
      rr = 2'($urandom_range(0, 3));
      rsp = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    rdy = 1'b1;
    drain();

    cv = 2'b11;
    repeat (3) step();
    total++;
    if (credits_o !== 3'd3)
      fail("pre_rst_credits", credits_o, 3);
    rst_n = 1'b0;
    #1;
    total++;
    if (credits_o !== 3'd0)
      fail("rst_mid_credits", credits_o, 0);
    total++;
    if (io_cmd_v_o !== 1'b0)
      fail("rst_mid_cmd_v", io_cmd_v_o, 0);
    total++;
    if (cmd_yumi_o !== 2'b00)
      fail("rst_mid_yumi", cmd_yumi_o, 0);
    total++;
    if (err_o !== 1'b0)
      fail("rst_mid_err", err_o, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    #1;
    total++;
    if (cmd_yumi_o !== 2'b01)
      fail("first_grant", cmd_yumi_o, 1);
    step();
    step();
    cv = 2'b00;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
